ag_issue_ctl: RTL and testbench
===============================

Name: ag_issue_ctl

Overview:
- Issue and interlock controller for the address-generation (AG) stage latch and the AG->ME handoff.
- Keeps a per-GPR pending-write scoreboard and stalls AG on RAW hazards or ME backpressure.
- Sequences mispredict flushes: squashes younger latches and backs squashed writes out of the scoreboard.
- Drives stall/inv for the DE->AG and AG->ME latches; those latches load when (~stall | inv).

Parameters:
- NREG, 8, number of architectural GPRs tracked (one bit per register in every mask)
- CNTW, 2, width of each per-register pending counter; saturates at 2^CNTW-1
- PCW, 16, width of the stall-cycle performance counter

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- ag_v  in  1  valid bit at the AG latch output
- ag_src_mask  in  NREG  GPRs read by the instruction in AG
- ag_dst_mask  in  NREG  GPRs written by the instruction in AG (dr1/dr2 decoded)
- me_ready  in  1  ME stage can accept an instruction this cycle
- me_v  in  1  valid bit at the ME latch output
- me_dst_mask  in  NREG  GPRs written by the instruction in ME
- wb_v  in  1  instruction retiring this cycle
- wb_dst_mask  in  NREG  GPRs written by the retiring instruction
- br_mispred  in  1  branch resolved mispredicted (pulse, post-ME)
- ag_stall  out  1  hold the DE->AG latch
- ag_inv  out  1  invalidate/force-load the DE->AG latch
- me_stall  out  1  hold the AG->ME latch
- me_inv  out  1  invalidate/force-load the AG->ME latch
- me_bubble  out  1  force v=0 on the AG->ME latch input
- issue  out  1  AG instruction transfers to ME this cycle
- state  out  2  FSM state code
- stall_cnt  out  PCW  count of cycles spent in S_DEP or S_MEM

Behaviour:
- Reset: state=S_RUN, all pending counters 0, stall_cnt 0, all outputs 0.
- hazard = ag_v & |(ag_src_mask & pending_nonzero).
- sat = ag_v & |(ag_dst_mask & counter_saturated).
- issue = ag_v & me_ready & ~hazard & ~sat & (state!=S_FLUSH) & ~br_mispred.
- ag_stall = ag_v & ~issue. This also applies to a mispredict cycle; ag_inv then overrides.
- me_bubble = ~issue.
- States:
  - S_RUN = 0. Normal operation.
  - S_DEP = 1. hazard or sat held last cycle.
  - S_MEM = 2. ~me_ready held last cycle with no hazard.
  - S_FLUSH = 3.
- Transitions: br_mispred -> S_FLUSH (highest priority) from any state. S_FLUSH -> S_RUN after exactly 1 cycle. Otherwise the next state follows the stall cause of the current cycle: hazard|sat -> S_DEP; else ~me_ready with ag_v -> S_MEM; else S_RUN.
- Flush, in the br_mispred cycle:
  - ag_inv = me_inv = 1, and issue is forced to 0.
  - For each bit set in me_dst_mask, the pending counter decrements if me_v.
  - Retire decrements (wb) still apply in the same cycle.
  - In S_FLUSH, ag_inv = 1 again for one more cycle (the refetch bubble); me_inv = 0.
- Counter update per register r, same cycle: next = cnt + inc - dec.
  - inc = issue & ag_dst_mask[r].
  - dec = (wb_v & wb_dst_mask[r]) + (br_mispred & me_v & me_dst_mask[r]).
  - Simultaneous inc and dec nets out.
  - Underflow is clamped at 0 and flagged by a simulation-only assertion.
  - Overflow cannot occur, because sat blocks issue.
- A source also present in the same instruction's dst mask is checked only against older pending writes. Issue is not blocked by its own write.
- me_stall = ~me_ready & me_v & ~br_mispred.
- stall_cnt increments when next-cycle state is S_DEP or S_MEM. It saturates at all-ones and holds; it does not wrap.
- Reset mid-flush returns to S_RUN immediately with counters cleared.

Decomposition:
- Shared package ag_ctl_pkg holds:
  - State encodings S_RUN/S_DEP/S_MEM/S_FLUSH.
  - NREG and CNTW defaults.
  - The mask typedef, a NREG-bit vector.
- Sub-module ag_scoreboard holds the NREG counters and exposes pending_nonzero/counter_saturated. It has inputs issue, ag_dst_mask, wb_v/wb_dst_mask and squash/me_dst_mask.
- The FSM and output logic stay in ag_issue_ctl.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle, with ag_v=1 -> all outputs 0, state=0, counters 0, stall_cnt 0.
- RAW hazard:
  - Issue with dst=0x01; the next instruction has src=0x01 -> ag_stall=1, state=1.
  - wb_v=1, wb_dst=0x01 -> issue=1 the following cycle.
- Saturation: issue three writers of 0x04 with no retire -> fourth writer has ag_stall=1; one wb of 0x04 -> issue resumes.
- Backpressure: me_ready=0 for 3 cycles with ag_v=1 and no hazard -> state=2, me_bubble=1, stall_cnt=3; me_ready=1 -> issue=1.
- Flush:
  - Setup: me_v=1, me_dst_mask=0x02, counter[1]=1; pulse br_mispred.
  - Same cycle: ag_inv=me_inv=1, issue=0.
  - Next cycle: state=3, ag_inv=1, counter[1]=0.
  - Following cycle: state=0.
- Flush with simultaneous retire: br_mispred with wb_dst=0x08, me_dst=0x08, counter[3]=2 -> counter[3]=0, no underflow assertion.

Source files
------------

// File: rtl/ag_ctl_pkg.sv
// Shared definitions for the AG issue/interlock controller.
package ag_ctl_pkg;

  localparam int unsigned NREG_DEF = 8;
  localparam int unsigned CNTW_DEF = 2;

  typedef logic [NREG_DEF-1:0] mask_t;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DEP   = 2'd1,
    S_MEM   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

endpackage

// File: rtl/ag_scoreboard.sv
// Per-GPR pending-write counters: incremented on issue, decremented on
// retire and on mispredict squash of the instruction sitting in ME.
module ag_scoreboard
  import ag_ctl_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned CNTW = CNTW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  input  logic [NREG-1:0] ag_dst_mask,
  input  logic            wb_v,
  input  logic [NREG-1:0] wb_dst_mask,
  input  logic            squash,
  input  logic [NREG-1:0] me_dst_mask,
  output logic [NREG-1:0] pending_nonzero,
  output logic [NREG-1:0] counter_saturated
);

  logic [CNTW-1:0] cnt     [NREG];
  logic [CNTW-1:0] cnt_nxt [NREG];
  logic [CNTW:0]   up      [NREG];
  logic [CNTW:0]   dn      [NREG];
  logic [NREG-1:0] underflow;

  // Net increment/decrement per register; a result below zero clamps to 0.
  always_comb begin
    underflow = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      up[r] = {1'b0, cnt[r]} + (CNTW+1)'(issue & ag_dst_mask[r]);
      dn[r] = (CNTW+1)'(wb_v & wb_dst_mask[r]) + (CNTW+1)'(squash & me_dst_mask[r]);
      if (up[r] < dn[r]) begin
        underflow[r] = 1'b1;
        cnt_nxt[r]   = '0;
      end else begin
        cnt_nxt[r]   = CNTW'(up[r] - dn[r]);
      end
    end
  end

  // Status flags consumed by the hazard and saturation checks.
  always_comb begin
    pending_nonzero   = '0;
    counter_saturated = '0;
    for (int unsigned r = 0; r < NREG; r++) begin
      pending_nonzero[r]   = (cnt[r] != '0);
      counter_saturated[r] = (cnt[r] == '1);
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) cnt[r] <= cnt_nxt[r];
    end
  end

`ifndef SYNTHESIS
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst) underflow == '0);
`endif

endmodule

// File: rtl/ag_issue_ctl.sv
// AG-stage issue controller: RAW/saturation interlock, ME backpressure,
// mispredict flush sequencing and stall-cycle accounting.
module ag_issue_ctl
  import ag_ctl_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF,
  parameter int unsigned CNTW = CNTW_DEF,
  parameter int unsigned PCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ag_v,
  input  logic [NREG-1:0] ag_src_mask,
  input  logic [NREG-1:0] ag_dst_mask,
  input  logic            me_ready,
  input  logic            me_v,
  input  logic [NREG-1:0] me_dst_mask,
  input  logic            wb_v,
  input  logic [NREG-1:0] wb_dst_mask,
  input  logic            br_mispred,
  output logic            ag_stall,
  output logic            ag_inv,
  output logic            me_stall,
  output logic            me_inv,
  output logic            me_bubble,
  output logic            issue,
  output logic [1:0]      state,
  output logic [PCW-1:0]  stall_cnt
);

  logic [NREG-1:0] pending_nonzero;
  logic [NREG-1:0] counter_saturated;
  logic            hazard;
  logic            sat;
  logic            issue_raw;
  logic            squash;
  state_t          cur_state;
  state_t          nxt_state;

  ag_scoreboard #(
    .NREG (NREG),
    .CNTW (CNTW)
  ) u_sb (
    .clk               (clk),
    .rst               (rst),
    .issue             (issue_raw),
    .ag_dst_mask       (ag_dst_mask),
    .wb_v              (wb_v),
    .wb_dst_mask       (wb_dst_mask),
    .squash            (squash),
    .me_dst_mask       (me_dst_mask),
    .pending_nonzero   (pending_nonzero),
    .counter_saturated (counter_saturated)
  );

  // Interlock decode and next-state selection (mispredict has top priority).
  always_comb begin
    hazard    = ag_v & |(ag_src_mask & pending_nonzero);
    sat       = ag_v & |(ag_dst_mask & counter_saturated);
    issue_raw = ag_v & me_ready & ~hazard & ~sat & (cur_state != S_FLUSH) & ~br_mispred;
    squash    = br_mispred & me_v;
    if (br_mispred)                nxt_state = S_FLUSH;
    else if (cur_state == S_FLUSH) nxt_state = S_RUN;
    else if (hazard | sat)         nxt_state = S_DEP;
    else if (~me_ready & ag_v)     nxt_state = S_MEM;
    else                           nxt_state = S_RUN;
  end

  // Latch controls; the combinational terms are qualified by rst so every
  // output reads 0 as soon as reset asserts, not just after the next edge.
  always_comb begin
    issue     = rst & issue_raw;
    ag_stall  = rst & ag_v & ~issue_raw;
    me_bubble = rst & ~issue_raw;
    ag_inv    = rst & (br_mispred | (cur_state == S_FLUSH));
    me_inv    = rst & br_mispred;
    me_stall  = rst & ~me_ready & me_v & ~br_mispred;
    state     = cur_state;
  end

  // State register and saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= S_RUN;
      stall_cnt <= '0;
    end else begin
      cur_state <= nxt_state;
      if (((nxt_state == S_DEP) || (nxt_state == S_MEM)) && (stall_cnt != '1))
        stall_cnt <= stall_cnt + PCW'(1);
    end
  end

endmodule

// File: tb/tb_ag_issue_ctl.sv
// Bench for ag_issue_ctl: directed vector table, reset sequence and
// randomized traffic against a per-register count model.
module tb_ag_issue_ctl;

  localparam int MAXC  = 3;   // 2-bit counters
  localparam int MAXSC = 15;  // stall_cnt width 4 in this bench

  logic       clk = 1'b0;
  logic       rst;
  logic       ag_v;
  logic [7:0] ag_src_mask;
  logic [7:0] ag_dst_mask;
  logic       me_ready;
  logic       me_v;
  logic [7:0] me_dst_mask;
  logic       wb_v;
  logic [7:0] wb_dst_mask;
  logic       br_mispred;
  logic       ag_stall;
  logic       ag_inv;
  logic       me_stall;
  logic       me_inv;
  logic       me_bubble;
  logic       issue;
  logic [1:0] state;
  logic [3:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  int mcnt [8];
  int mstate;
  int msc;

  typedef struct {
    logic       ag_v;
    logic [7:0] src;
    logic [7:0] dst;
    logic       me_ready;
    logic       me_v;
    logic [7:0] me_dst;
    logic       wb_v;
    logic [7:0] wb_dst;
    logic       br;
    logic       e_issue;
    logic       e_stall;
    logic       e_ag_inv;
    logic       e_me_inv;
    int         e_state;
    int         e_sc;
  } vec_t;

  vec_t tbl [$];

  ag_issue_ctl #(
    .NREG (8),
    .CNTW (2),
    .PCW  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ag_v        (ag_v),
    .ag_src_mask (ag_src_mask),
    .ag_dst_mask (ag_dst_mask),
    .me_ready    (me_ready),
    .me_v        (me_v),
    .me_dst_mask (me_dst_mask),
    .wb_v        (wb_v),
    .wb_dst_mask (wb_dst_mask),
    .br_mispred  (br_mispred),
    .ag_stall    (ag_stall),
    .ag_inv      (ag_inv),
    .me_stall    (me_stall),
    .me_inv      (me_inv),
    .me_bubble   (me_bubble),
    .issue       (issue),
    .state       (state),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic av, input logic [7:0] src, input logic [7:0] dst,
                              input logic rdy, input logic mev, input logic [7:0] medst,
                              input logic wbv, input logic [7:0] wbdst, input logic br,
                              input logic ei, input logic es, input logic eai, input logic emi,
                              input int est, input int esc);
    vec_t v;
    v.ag_v = av; v.src = src; v.dst = dst; v.me_ready = rdy; v.me_v = mev;
    v.me_dst = medst; v.wb_v = wbv; v.wb_dst = wbdst; v.br = br;
    v.e_issue = ei; v.e_stall = es; v.e_ag_inv = eai; v.e_me_inv = emi;
    v.e_state = est; v.e_sc = esc;
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 8; r++) mcnt[r] = 0;
    mstate = 0;
    msc    = 0;
  endtask

  // One clock: drive at posedge+1, compare at negedge, advance model, return at posedge+1.
  task automatic step(input vec_t v, input bit has_exp);
    bit hz, st, iss, fl;
    int nst;
    ag_v = v.ag_v; ag_src_mask = v.src; ag_dst_mask = v.dst; me_ready = v.me_ready;
    me_v = v.me_v; me_dst_mask = v.me_dst; wb_v = v.wb_v; wb_dst_mask = v.wb_dst;
    br_mispred = v.br;
    fl = (mstate == 3);
    hz = 1'b0;
    st = 1'b0;
    for (int r = 0; r < 8; r++) begin
      if (v.ag_v && v.src[r] && mcnt[r] > 0)     hz = 1'b1;
      if (v.ag_v && v.dst[r] && mcnt[r] == MAXC) st = 1'b1;
    end
    iss = v.ag_v && v.me_ready && !hz && !st && !fl && !v.br;
    @(negedge clk);
    chk("issue",     int'(issue),     int'(iss));
    chk("ag_stall",  int'(ag_stall),  int'(v.ag_v && !iss));
    chk("ag_inv",    int'(ag_inv),    int'(v.br || fl));
    chk("me_inv",    int'(me_inv),    int'(v.br));
    chk("me_stall",  int'(me_stall),  int'(!v.me_ready && v.me_v && !v.br));
    chk("me_bubble", int'(me_bubble), int'(!iss));
    chk("state",     int'(state),     mstate);
    chk("stall_cnt", int'(stall_cnt), msc);
    if (has_exp) begin
      chk("tbl_issue",    int'(issue),     int'(v.e_issue));
      chk("tbl_ag_stall", int'(ag_stall),  int'(v.e_stall));
      chk("tbl_ag_inv",   int'(ag_inv),    int'(v.e_ag_inv));
      chk("tbl_me_inv",   int'(me_inv),    int'(v.e_me_inv));
      chk("tbl_state",    int'(state),     v.e_state);
      chk("tbl_stall_cnt",int'(stall_cnt), v.e_sc);
    end
    for (int r = 0; r < 8; r++) begin
      mcnt[r] += int'(iss && v.dst[r]) - int'(v.wb_v && v.wb_dst[r])
               - int'(v.br && v.me_v && v.me_dst[r]);
      if (mcnt[r] < 0) mcnt[r] = 0;
    end
    if (v.br)                     nst = 3;
    else if (fl)                  nst = 0;
    else if (hz || st)            nst = 1;
    else if (!v.me_ready && v.ag_v) nst = 2;
    else                          nst = 0;
    if ((nst == 1 || nst == 2) && msc < MAXSC) msc++;
    mstate = nst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [7:0] nz;
    rst = 1'b0; ag_v = 1'b0; ag_src_mask = '0; ag_dst_mask = '0; me_ready = 1'b1;
    me_v = 1'b0; me_dst_mask = '0; wb_v = 1'b0; wb_dst_mask = '0; br_mispred = 1'b0;
    model_reset();

    // directed table, applied from a fresh reset
    tbl.push_back(mk(1, 8'h01, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0)); // cleared by reset
    tbl.push_back(mk(1, 8'h00, 8'h01, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h01, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h01, 8'h00, 1, 0, 8'h00, 1, 8'h01, 0, 0, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 8'h01, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 1, 2));
    tbl.push_back(mk(1, 8'h00, 8'h04, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h00, 8'h04, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h00, 8'h04, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h00, 8'h04, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(1, 8'h00, 8'h04, 1, 0, 8'h00, 1, 8'h04, 0, 0, 1, 0, 0, 1, 3));
    tbl.push_back(mk(1, 8'h00, 8'h04, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 1, 4));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 8'h04, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 8'h04, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 1, 8'h04, 0, 0, 0, 0, 0, 0, 4));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 0, 4));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 2, 5));
    tbl.push_back(mk(1, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 0, 2, 6));
    tbl.push_back(mk(1, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 2, 7));
    tbl.push_back(mk(1, 8'h00, 8'h02, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 7));
    tbl.push_back(mk(1, 8'h00, 8'h00, 1, 1, 8'h02, 0, 8'h00, 1, 0, 1, 1, 1, 0, 7));
    tbl.push_back(mk(1, 8'h02, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0, 1, 1, 0, 3, 7));
    tbl.push_back(mk(1, 8'h02, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 7));
    tbl.push_back(mk(1, 8'h00, 8'h08, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 7));
    tbl.push_back(mk(1, 8'h00, 8'h08, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 7));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 1, 8'h08, 1, 8'h08, 1, 0, 0, 1, 1, 0, 7));
    tbl.push_back(mk(0, 8'h00, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 1, 0, 3, 7));
    tbl.push_back(mk(1, 8'h08, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 7));

    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    // build up pending state, then assert reset mid-cycle
    step(mk(1, 8'h00, 8'h01, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    step(mk(1, 8'h01, 8'h00, 1, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0), 1'b0);
    ag_v = 1'b1; ag_src_mask = 8'h00; ag_dst_mask = 8'h00; me_ready = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("rst_issue",     int'(issue),     0);
    chk("rst_ag_stall",  int'(ag_stall),  0);
    chk("rst_ag_inv",    int'(ag_inv),    0);
    chk("rst_me_inv",    int'(me_inv),    0);
    chk("rst_me_stall",  int'(me_stall),  0);
    chk("rst_me_bubble", int'(me_bubble), 0);
    chk("rst_state",     int'(state),     0);
    chk("rst_stall_cnt", int'(stall_cnt), 0);
    model_reset();
    @(posedge clk);
    #1;
    chk("rst_hold_state", int'(state),     0);
    chk("rst_hold_cnt",   int'(stall_cnt), 0);
    ag_v = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) step(tbl[i], 1'b1);

    // randomized traffic; retires and squashes only target pending registers
    for (int n = 0; n < 400; n++) begin
      nz = '0;
      for (int r = 0; r < 8; r++) nz[r] = (mcnt[r] > 0);
      v = mk(0, 8'h00, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0);
      v.ag_v     = ($urandom % 4) != 0;
      v.src      = 8'($urandom & $urandom & $urandom);
      v.dst      = 8'($urandom & $urandom);
      v.me_ready = ($urandom % 4) != 0;
      v.me_v     = 1'($urandom % 2);
      v.br       = ($urandom % 12) == 0;
      v.wb_v     = 1'($urandom % 2);
      v.wb_dst   = v.wb_v ? (8'($urandom) & nz) : 8'($urandom);
      if (v.br && v.me_v)
        v.me_dst = 8'($urandom) & nz & (v.wb_v ? ~v.wb_dst : 8'hff);
      else
        v.me_dst = 8'($urandom);
      step(v, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
